// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    localparam int unsigned UART_FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for uart_rx_fifo: one synchronous write port, one async read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned depth     = UART_FIFO_DEPTH_DEFAULT,
    parameter int unsigned addr_bits = $clog2(depth)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [addr_bits-1:0] i_waddr,
    input  uart_byte_t           i_wdata,
    input  logic [addr_bits-1:0] i_raddr,
    output uart_byte_t           o_rdata
);

    uart_byte_t mem_q [depth];

    // Contents are deliberately left unreset; occupancy is tracked by the owner.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO behind uart_rx with fill level and sticky overflow.
// Define UART_FIFO_SUM_EN to keep a running 32-bit sum of popped bytes on o_sum.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned depth = UART_FIFO_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         i_data,
    input  logic               i_valid,
    input  logic               i_ready,
    output logic [7:0]         o_data,
    output logic               o_valid,
    output logic [$clog2(depth):0] o_count,
    output logic               o_full,
    output logic               o_overflow,
    output logic [31:0]        o_sum
);

    localparam int unsigned addr_bits = $clog2(depth);
    localparam logic [addr_bits:0] full_count = (addr_bits + 1)'(depth);

    logic [addr_bits-1:0] rd_ptr_q, rd_ptr_d;
    logic [addr_bits-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_bits:0]   count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 push, pop;
    uart_byte_t           rdata;

    uart_fifo_mem #(
        .depth     (depth),
        .addr_bits (addr_bits)
    ) u_mem (
        .clk     (clk),
        .i_we    (push),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_data),
        .i_raddr (rd_ptr_q),
        .o_rdata (rdata)
    );

    always_comb begin
        o_valid = (count_q != '0);
        o_full  = (count_q == full_count);
        o_count = count_q;
        o_data  = o_valid ? rdata : 8'h00;
        pop     = i_ready && o_valid;
        // Popping frees a slot in the same cycle, so a full FIFO can still accept a push.
        push    = i_valid && (!o_full || pop);

        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        overflow_d = overflow_q || (i_valid && !push);

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_overflow = overflow_q;

`ifdef UART_FIFO_SUM_EN
    logic [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = pop ? sum_q + {24'b0, o_data} : sum_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign o_sum = sum_q;
`else
    assign o_sum = 32'h0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized check of uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_data = 8'h00;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [7:0]  o_data;
    logic        o_valid;
    logic [4:0]  o_count;
    logic        o_full;
    logic        o_overflow;
    logic [31:0] o_sum;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [7:0]  m_q [$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_sum = 32'h0;

    uart_rx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_overflow (o_overflow),
        .o_sum      (o_sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 8'h00;
        chk("valid", 32'(o_valid), 32'(m_q.size() > 0));
        chk("data", 32'(o_data), 32'(head));
        chk("count", 32'(o_count), 32'(m_q.size()));
        chk("full", 32'(o_full), 32'(m_q.size() == DEPTH));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        chk("sum", o_sum, m_sum);
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic r);
        bit was_full;
        bit pop;
        was_full = (m_q.size() == DEPTH);
        pop = r && (m_q.size() > 0);
        if (pop) begin
`ifdef UART_FIFO_SUM_EN
            m_sum = m_sum + 32'(m_q[0]);
`endif
            void'(m_q.pop_front());
        end
        if (v) begin
            if (!was_full || pop) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    // Check the state left by the previous cycle, then drive and model this cycle.
    task automatic cycle(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        check_all();
        i_valid = v;
        i_data  = d;
        i_ready = r;
        model_step(v, d, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        m_sum = 32'h0;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Single byte through, then pop.
        cycle(1'b1, 8'h48, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t1_head", 32'(o_data), 32'h48);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Fill to depth, then overflow while full.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t3_head", 32'(o_data), 32'h00);

        // Full with simultaneous push/pop keeps count at depth.
        cycle(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Empty with push and pop together: pop ignored.
        cycle(1'b1, 8'h3C, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t5_count", 32'(o_count), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);

        // Sum sequence, then reset mid-stream.
        do_reset();
        cycle(1'b1, 8'h48, 1'b0);
        cycle(1'b1, 8'h65, 1'b0);
        cycle(1'b1, 8'h6C, 1'b0);
        cycle(1'b1, 8'h21, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
`ifdef UART_FIFO_SUM_EN
        chk("t6_sum", o_sum, 32'h119);
`endif
        do_reset();
        cycle(1'b1, 8'h7E, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);

        // Randomized traffic, alternating fill-biased and drain-biased phases.
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 150; i++) begin
                logic v, r;
                v = ($urandom_range(99) < ((p % 2 == 0) ? 75 : 30));
                r = ($urandom_range(99) < ((p % 2 == 0) ? 30 : 75));
                cycle(v, 8'($urandom), r);
            end
            if (p == 4) do_reset();
        end
        cycle(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
